// File: rtl/torus_out_arbiter.sv
// torus_out_arbiter: one router output port. Round-robin arbitration among
// N_IN requesting inputs, credit-based backpressure toward the downstream
// buffer, and a registered output link.
//
// Handshake: input i hands over its flit in any cycle where req[i] & gnt[i].
// gnt is combinational from req, the rotating pointer and the credit count.
// It does not depend on credit_in, so a returned credit first counts in the
// following cycle. The link side is valid-only: out_v marks a flit on out.
// There is no ready signal on the link. Flow control comes from credits,
// where each credit_in pulse returns one downstream slot.
module torus_out_arbiter #(
  parameter int N_IN      = 5,
  parameter int X_W       = 2,
  parameter int Y_W       = 2,
  parameter int D_W       = 28,
  parameter int FLIT_W    = X_W + Y_W + D_W,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          req,
  input  logic [N_IN*FLIT_W-1:0]   in_flit,
  output logic [N_IN-1:0]          gnt,
  output logic                     out_v,
  output logic [FLIT_W-1:0]        out,
  input  logic                     credit_in,
  output logic [CNT_W-1:0]         credits,
  output logic                     ovf_err
);

  localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  win;
  logic [PTR_W:0]    idx;
  logic              found;
  logic              grant;
  logic [FLIT_W-1:0] flit_arr [N_IN];

  // Unpack the flat flit bus into one entry per input.
  for (genvar g = 0; g < N_IN; g++) begin : g_unpack
    assign flit_arr[g] = in_flit[g*FLIT_W +: FLIT_W];
  end

  // Rotating-priority search starting at ptr. The grant is suppressed
  // when there are no credits or while reset is asserted.
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    grant = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(N_IN)) begin
        idx = idx - (PTR_W+1)'(N_IN);
      end
      if (!found && req[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = idx[PTR_W-1:0];
      end
    end
    grant = found && !rst && (credits != '0);
    if (grant) begin
      gnt[win] = 1'b1;
    end
  end

  // Register the winning flit onto the link and advance the pointer past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      out_v <= 1'b0;
      out   <= '0;
    end else begin
      out_v <= grant;
      if (grant) begin
        out <= flit_arr[win];
        ptr <= (win == PTR_W'(N_IN - 1)) ? '0 : win + PTR_W'(1);
      end
    end
  end

  // Credit accounting. A grant and a returned credit in the same cycle cancel out.
  // A credit returned while the counter is full is dropped and flagged sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CNT_W'(BUF_DEPTH);
      ovf_err <= 1'b0;
    end else if (grant && !credit_in) begin
      credits <= credits - CNT_W'(1);
    end else if (!grant && credit_in) begin
      if (credits == CNT_W'(BUF_DEPTH)) begin
        ovf_err <= 1'b1;
      end else begin
        credits <= credits + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_torus_out_arbiter.sv
// Testbench for torus_out_arbiter: scenario tasks plus a flit scoreboard
// fed from a small reference model of the arbiter.
module tb_torus_out_arbiter;

  localparam int N_IN      = 5;
  localparam int FLIT_W    = 32;
  localparam int BUF_DEPTH = 4;
  localparam int CNT_W     = 3;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_IN-1:0]        req = '0;
  logic [N_IN*FLIT_W-1:0] in_flit = '0;
  logic                   credit_in = 1'b0;
  logic [N_IN-1:0]        gnt;
  logic                   out_v;
  logic [FLIT_W-1:0]      out;
  logic [CNT_W-1:0]       credits;
  logic                   ovf_err;

  torus_out_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in_flit   (in_flit),
    .gnt       (gnt),
    .out_v     (out_v),
    .out       (out),
    .credit_in (credit_in),
    .credits   (credits),
    .ovf_err   (ovf_err)
  );

  // Reference model state and scoreboard
  int                n_checks = 0;
  int                n_fail   = 0;
  int                m_ptr     = 0;
  int                m_credits = BUF_DEPTH;
  logic              m_ovf     = 1'b0;
  logic              m_out_v   = 1'b0;
  logic              mon_en    = 1'b0;
  logic [FLIT_W-1:0] exp_q[$];

  function automatic int model_pick();
    if (rst || m_credits == 0) return -1;
    for (int k = 0; k < N_IN; k++) begin
      int i;
      i = (m_ptr + k) % N_IN;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N_IN-1:0] model_gnt();
    int w;
    w = model_pick();
    if (w < 0) return '0;
    return N_IN'(1) << w;
  endfunction

  // Advance one clock: update the model from the inputs of this cycle.
  task automatic tick();
    int w;
    @(negedge clk);
    #1;
    w = model_pick();
    if (rst) begin
      m_ptr     = 0;
      m_credits = BUF_DEPTH;
      m_ovf     = 1'b0;
      m_out_v   = 1'b0;
    end else begin
      m_out_v = (w >= 0);
      if (w >= 0) begin
        exp_q.push_back(in_flit[w*FLIT_W +: FLIT_W]);
        m_ptr = (w == N_IN - 1) ? 0 : w + 1;
      end
      if (w >= 0 && !credit_in) begin
        m_credits = m_credits - 1;
      end else if (w < 0 && credit_in) begin
        if (m_credits == BUF_DEPTH) m_ovf = 1'b1;
        else m_credits = m_credits + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_flits();
    for (int i = 0; i < N_IN; i++) in_flit[i*FLIT_W +: FLIT_W] = $urandom;
  endtask

  // Link scoreboard: out_v must match the model and each flit must match the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (out_v !== m_out_v) begin
        n_fail++;
        $display("FAIL out_v: got %b expected %b at %0t", out_v, m_out_v, $time);
      end
      if (m_out_v) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_flit: got %h expected none queued at %0t", out, $time);
        end else begin
          logic [FLIT_W-1:0] e;
          e = exp_q.pop_front();
          if (out !== e) begin
            n_fail++;
            $display("FAIL out_flit: got %h expected %h at %0t", out, e, $time);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; req = '0; credit_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) req = '1;
      #1;
      n_checks++;
      if (gnt !== '0) begin
        n_fail++; $display("FAIL reset_gnt[%0d]: got %b expected 00000", c, gnt);
      end
      tick();
    end
    rst = 1'b0; req = '0;
    #1;
    n_checks++;
    if (gnt !== '0 || out_v !== 1'b0 || credits !== CNT_W'(4) || ovf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got gnt=%b out_v=%b credits=%0d ovf=%b expected 0 0 4 0",
               gnt, out_v, credits, ovf_err);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 2, 3, 4, 0};
    req = 5'b11111; credit_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      logic [N_IN-1:0] e;
      rand_flits();
      e = N_IN'(1) << order[c];
      #1;
      n_checks++;
      if (gnt !== e) begin
        n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt, e);
      end
      n_checks++;
      if (credits !== CNT_W'(4)) begin
        n_fail++; $display("FAIL rr_credits[%0d]: got %0d expected 4", c, credits);
      end
      if (c > 0) begin
        n_checks++;
        if (out_v !== 1'b1) begin
          n_fail++; $display("FAIL rr_out_v[%0d]: got %b expected 1", c, out_v);
        end
      end
      tick();
    end
  endtask

  task automatic test_credit_exhaust();
    req = 5'b01000;
    for (int c = 0; c < 8; c++) begin
      logic [N_IN-1:0] e;
      int ec;
      credit_in = (c == 6);
      rand_flits();
      e  = (c < 4 || c == 7) ? 5'b01000 : 5'b00000;
      ec = (c <= 4) ? 4 - c : ((c == 7) ? 1 : 0);
      #1;
      n_checks++;
      if (gnt !== e) begin
        n_fail++; $display("FAIL exhaust_gnt[%0d]: got %b expected %b", c, gnt, e);
      end
      n_checks++;
      if (credits !== CNT_W'(ec)) begin
        n_fail++; $display("FAIL exhaust_credits[%0d]: got %0d expected %0d", c, credits, ec);
      end
      tick();
    end
    credit_in = 1'b0;
  endtask

  task automatic test_credit_bypass();
    req = 5'b00100; credit_in = 1'b1;
    rand_flits();
    #1;
    n_checks++;
    if (gnt !== 5'b00000 || credits !== CNT_W'(0)) begin
      n_fail++; $display("FAIL bypass_zero: got gnt=%b credits=%0d expected 00000 0", gnt, credits);
    end
    tick();
    rand_flits();
    #1;
    n_checks++;
    if (gnt !== 5'b00100 || credits !== CNT_W'(1)) begin
      n_fail++; $display("FAIL bypass_one: got gnt=%b credits=%0d expected 00100 1", gnt, credits);
    end
    tick();
    req = '0; credit_in = 1'b0;
    #1;
    n_checks++;
    if (credits !== CNT_W'(1)) begin
      n_fail++; $display("FAIL bypass_cancel: got %0d expected 1", credits);
    end
    tick();
    credit_in = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    credit_in = 1'b0;
    #1;
    n_checks++;
    if (credits !== CNT_W'(4)) begin
      n_fail++; $display("FAIL refill: got %0d expected 4", credits);
    end
  endtask

  task automatic test_overflow();
    req = '0; credit_in = 1'b1;
    #1;
    n_checks++;
    if (ovf_err !== 1'b0) begin
      n_fail++; $display("FAIL ovf_before: got %b expected 0", ovf_err);
    end
    tick();
    credit_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req = (c < 2) ? 5'b11111 : 5'b00000;
      credit_in = (c >= 2 && c < 4);
      rand_flits();
      #1;
      n_checks++;
      if (ovf_err !== 1'b1) begin
        n_fail++; $display("FAIL ovf_sticky[%0d]: got %b expected 1", c, ovf_err);
      end
      n_checks++;
      if (credits !== CNT_W'(m_credits) || gnt !== model_gnt()) begin
        n_fail++; $display("FAIL ovf_state[%0d]: got credits=%0d gnt=%b expected %0d %b",
                           c, credits, gnt, m_credits, model_gnt());
      end
      tick();
    end
    req = '0; credit_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (ovf_err !== 1'b0 || credits !== CNT_W'(4)) begin
      n_fail++; $display("FAIL ovf_clear: got ovf=%b credits=%0d expected 0 4", ovf_err, credits);
    end
  endtask

  task automatic test_priority_wrap();
    req = 5'b01000; credit_in = 1'b1;
    rand_flits();
    tick();
    req = 5'b10001;
    rand_flits();
    in_flit[4*FLIT_W +: FLIT_W] = {2'd1, 2'd3, 28'hABCDEF0};
    #1;
    n_checks++;
    if (gnt !== 5'b10000) begin
      n_fail++; $display("FAIL wrap_gnt4: got %b expected 10000", gnt);
    end
    tick();
    req = 5'b00001;
    rand_flits();
    #1;
    n_checks++;
    if (gnt !== 5'b00001) begin
      n_fail++; $display("FAIL wrap_gnt0: got %b expected 00001", gnt);
    end
    n_checks++;
    if (out_v !== 1'b1 || out !== 32'h7ABCDEF0) begin
      n_fail++; $display("FAIL wrap_out: got v=%b %h expected 1 7abcdef0", out_v, out);
    end
    tick();
    rst = 1'b1; req = 5'b11111;
    #1;
    n_checks++;
    if (gnt !== '0 || out_v !== 1'b1) begin
      n_fail++; $display("FAIL midrst_gnt: got gnt=%b out_v=%b expected 00000 1", gnt, out_v);
    end
    tick();
    rst = 1'b0; req = '0; credit_in = 1'b0;
    #1;
    n_checks++;
    if (out_v !== 1'b0) begin
      n_fail++; $display("FAIL midrst_out_v: got %b expected 0", out_v);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 60; c++) begin
      req = N_IN'($urandom_range(0, 31));
      credit_in = 1'($urandom_range(0, 1));
      rand_flits();
      #1;
      n_checks++;
      if (gnt !== model_gnt()) begin
        n_fail++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", c, gnt, model_gnt());
      end
      n_checks++;
      if (credits !== CNT_W'(m_credits) || ovf_err !== m_ovf) begin
        n_fail++; $display("FAIL b2b_credits[%0d]: got %0d/%b expected %0d/%b",
                           c, credits, ovf_err, m_credits, m_ovf);
      end
      tick();
    end
    req = '0; credit_in = 1'b0;
    tick();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL drain: got %0d flits left expected 0", exp_q.size());
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    test_reset();
    test_round_robin();
    test_credit_exhaust();
    test_credit_bypass();
    test_overflow();
    test_priority_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
